sequence_playback: RTL

//  Plays the stored colour segment back to the player before each round of Simon Says.
//  It is the output-side counterpart of the input checker.
//  On start, lights the one-hot LED for segment[0..round] in order, each colour for a fixed on-time followed by a dark gap.

---
 rtl/simon_pkg.sv | 42 ++++
 rtl/pb_timer.sv | 34 +++
 rtl/sequence_playback.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// ============================================================================
// Package     : simon_pkg
// Description : Colour encoding, playback state type and helpers shared by
//               the Simon Says playback and input-checker blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

    localparam int SEG_LEN = 33;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } pb_state_t;

    function automatic logic [3:0] onehot(input color_t c);
        logic [3:0] v;
        v = 4'b0001 << c;
        return v;
    endfunction

    // Rounds past the end of the segment replay the whole segment, never wrap.
    function automatic logic [5:0] clamp_round(input logic [5:0] r);
        logic [5:0] v;
        v = (r > 6'(SEG_LEN - 1)) ? 6'(SEG_LEN - 1) : r;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pb_timer.sv
// ============================================================================
// Module      : pb_timer
// Description : Loadable down-counter; tc_o is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/sequence_playback.sv
// ============================================================================
// Module      : sequence_playback
// Description : Plays segment[0..round] on one-hot LEDs, each colour lit for
//               an on-time then dark for a gap, then pulses done.
//               Optional macro PLAYBACK_SPEEDUP_EN shortens on-time in later
//               rounds (ON_CYCLES >> (last/8), minimum 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_playback
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [5:0]              round,
    input  logic [SEG_LEN-1:0][1:0] segment,
    output logic [3:0]              led,
    output logic                    busy,
    output logic                    done
);

    localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] C_GAP_LOAD = TW'(GAP_CYCLES - 1);

    pb_state_t   state_q;
    logic [5:0]  index_q;
    logic [5:0]  last_q;
    logic [5:0]  w_last_new;
    logic [TW-1:0] w_on_load;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_tc;

    assign w_last_new = clamp_round(round);

`ifdef PLAYBACK_SPEEDUP_EN
    // The shift is taken from the round being started while IDLE, otherwise
    // from the latched value, so the first ON phase already runs fast.
    logic [5:0]    w_last_sel;
    logic [2:0]    w_shift;
    logic [TW-1:0] w_on_eff;

    assign w_last_sel = (state_q == IDLE) ? w_last_new : last_q;
    assign w_shift    = w_last_sel[5:3];
    assign w_on_eff   = TW'(ON_CYCLES) >> w_shift;
    assign w_on_load  = (w_on_eff == '0) ? '0 : (w_on_eff - 1'b1);
`else
    assign w_on_load  = TW'(ON_CYCLES - 1);
`endif

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (state_q)
            IDLE: begin
                w_load     = start;
                w_load_val = w_on_load;
            end
            ON: begin
                w_load     = w_tc;
                w_load_val = C_GAP_LOAD;
            end
            GAP: begin
                w_load     = w_tc && (index_q != last_q);
                w_load_val = w_on_load;
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = '0;
            end
        endcase
    end

    pb_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .tc_o       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            last_q  <= '0;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= ON;
                        last_q  <= w_last_new;
                        index_q <= '0;
                        led     <= onehot(color_t'(segment[0]));
                        busy    <= 1'b1;
                    end
                end
                ON: begin
                    if (w_tc) begin
                        state_q <= GAP;
                        led     <= '0;
                    end
                end
                GAP: begin
                    if (w_tc) begin
                        if (index_q == last_q) begin
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q <= ON;
                            index_q <= index_q + 6'd1;
                            led     <= onehot(color_t'(segment[index_q + 6'd1]));
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    led     <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
